// File: rtl/hex_page_scheduler.sv
// Round-robin time-share of HEX0..HEX5/LEDR between clients A and B; HEX_LZ_BLANK_EN enables leading-zero blanking.
// Latency: valid sampled in IDLE shows the page one cycle later; each page dwells DWELL cycles plus held cycles.
// Backpressure: none; dropping a valid abandons its page, and HOLD freezes the dwell counter.
module hex_page_scheduler #(
   parameter int DWELL = 50_000_000
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic        A_VALID,
   input  logic [23:0] A_DATA,
   input  logic        B_VALID,
   input  logic [23:0] B_DATA,
   input  logic        HOLD,
   output logic [7:0]  HEX0,
   output logic [7:0]  HEX1,
   output logic [7:0]  HEX2,
   output logic [7:0]  HEX3,
   output logic [7:0]  HEX4,
   output logic [7:0]  HEX5,
   output logic [1:0]  LEDR,
   output logic        PAGE_DONE
);
   localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

   typedef enum logic [1:0] {IDLE, SHOW_A, SHOW_B} state_t;

   state_t        state, state_nxt, other;
   logic [CW-1:0] cnt;
   logic [23:0]   page, load_dat;
   logic          load, inc, own_vld, oth_vld;
   logic [7:0]    digit [6];
`ifdef HEX_LZ_BLANK_EN
   logic          zero_above;
`endif

   function automatic logic [7:0] seg7(input logic [3:0] n);
      case (n)
         4'h0: seg7 = 8'hC0;
         4'h1: seg7 = 8'hF9;
         4'h2: seg7 = 8'hA4;
         4'h3: seg7 = 8'hB0;
         4'h4: seg7 = 8'h99;
         4'h5: seg7 = 8'h92;
         4'h6: seg7 = 8'h82;
         4'h7: seg7 = 8'hF8;
         4'h8: seg7 = 8'h80;
         4'h9: seg7 = 8'h90;
         4'hA: seg7 = 8'h88;
         4'hB: seg7 = 8'h83;
         4'hC: seg7 = 8'hC6;
         4'hD: seg7 = 8'hA1;
         4'hE: seg7 = 8'h86;
         default: seg7 = 8'h8E;
      endcase
   endfunction

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      inc       = 1'b0;
      PAGE_DONE = 1'b0;
      own_vld   = (state == SHOW_A) ? A_VALID : B_VALID;
      oth_vld   = (state == SHOW_A) ? B_VALID : A_VALID;
      other     = (state == SHOW_A) ? SHOW_B : SHOW_A;
      case (state)
         IDLE: begin
            if (A_VALID) begin
               state_nxt = SHOW_A;
               load      = 1'b1;
            end else if (B_VALID) begin
               state_nxt = SHOW_B;
               load      = 1'b1;
            end
         end
         default: begin
            // abandon is checked first so it wins over a same-cycle expiry
            if (!own_vld) begin
               if (oth_vld) begin
                  state_nxt = other;
                  load      = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end else if (cnt == CNT_LAST && !HOLD) begin
               PAGE_DONE = 1'b1;
               load      = 1'b1;
               state_nxt = oth_vld ? other : state;
            end else if (!HOLD) begin
               inc = 1'b1;
            end
         end
      endcase
      load_dat = (state_nxt == SHOW_A) ? A_DATA : B_DATA;
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         page  <= '0;
      end else begin
         state <= state_nxt;
         if (load) begin
            page <= load_dat;
            cnt  <= '0;
         end else if (inc) begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   always_comb begin
      for (int k = 0; k < 6; k++) digit[k] = seg7(page[4*k +: 4]);
`ifdef HEX_LZ_BLANK_EN
      zero_above = 1'b1;
      for (int k = 5; k >= 1; k--) begin
         if (zero_above && page[4*k +: 4] == 4'h0) digit[k] = 8'hFF;
         else zero_above = 1'b0;
      end
`endif
      if (state == IDLE)
         for (int k = 0; k < 6; k++) digit[k] = 8'hFF;
   end

   assign HEX0 = digit[0];
   assign HEX1 = digit[1];
   assign HEX2 = digit[2];
   assign HEX3 = digit[3];
   assign HEX4 = digit[4];
   assign HEX5 = digit[5];
   assign LEDR = {state == SHOW_B, state == SHOW_A};

endmodule

// File: tb/tb_hex_page_scheduler.sv
// Bench for hex_page_scheduler with DWELL=4: constant vector table, hand sequences, then random traffic vs a reference model.
module tb_hex_page_scheduler;
   localparam int DWELL = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        a_valid, b_valid, hold;
   logic [23:0] a_data, b_data;
   logic [7:0]  hex0, hex1, hex2, hex3, hex4, hex5;
   logic [1:0]  ledr;
   logic        page_done;

   int total = 0;
   int bad   = 0;

   hex_page_scheduler #(.DWELL(DWELL)) dut (
      .CLOCK_50(clk), .reset(reset),
      .A_VALID(a_valid), .A_DATA(a_data),
      .B_VALID(b_valid), .B_DATA(b_data),
      .HOLD(hold),
      .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3), .HEX4(hex4), .HEX5(hex5),
      .LEDR(ledr), .PAGE_DONE(page_done)
   );

   always #5 clk = ~clk;

   // reference model: owner 0=none 1=A 2=B, rem = unheld cycles left in the dwell
   int          owner = 0;
   int          rem   = 0;
   logic [23:0] mpage = '0;
   logic [7:0]  seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   function automatic logic [47:0] model_hex();
      logic [47:0] r;
      int top;
      r = '1;
      if (owner != 0) begin
         top = 0;
         for (int k = 0; k < 6; k++) if (mpage[4*k +: 4] != 4'h0) top = k;
         for (int k = 0; k < 6; k++) begin
            r[8*k +: 8] = seg_tab[mpage[4*k +: 4]];
`ifdef HEX_LZ_BLANK_EN
            if (k > top) r[8*k +: 8] = 8'hFF;
`endif
         end
      end
      return r;
   endfunction

   function automatic logic [1:0] model_led();
      return (owner == 1) ? 2'b01 : (owner == 2) ? 2'b10 : 2'b00;
   endfunction

   function automatic logic model_own_valid();
      return (owner == 1) ? a_valid : b_valid;
   endfunction

   function automatic logic model_pd();
      return owner != 0 && model_own_valid() && !hold && rem == 1;
   endfunction

   task automatic model_start(input int who);
      owner = who;
      mpage = (who == 1) ? a_data : b_data;
      rem   = DWELL;
   endtask

   task automatic model_step();
      logic ov, xv;
      if (reset) begin
         owner = 0;
         mpage = '0;
      end else if (owner == 0) begin
         if (a_valid) model_start(1);
         else if (b_valid) model_start(2);
      end else begin
         ov = model_own_valid();
         xv = (owner == 1) ? b_valid : a_valid;
         if (!ov) begin
            if (xv) model_start(3 - owner);
            else owner = 0;
         end else if (!hold && rem == 1) begin
            model_start(xv ? 3 - owner : owner);
         end else if (!hold) begin
            rem--;
         end
      end
   endtask

   task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [47:0] hex_all();
      return {hex5, hex4, hex3, hex2, hex1, hex0};
   endfunction

   task automatic sample();
      @(negedge clk);
      chk("model_hex", hex_all(), model_hex());
      chk("model_ledr", 48'(ledr), 48'(model_led()));
      chk("model_page_done", 48'(page_done), 48'(model_pd()));
   endtask

   task automatic adv();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic tick();
      sample();
      adv();
   endtask

   typedef struct {
      logic        a_v;
      logic [23:0] a_d;
      logic        b_v;
      logic [23:0] b_d;
      logic        h;
      logic [47:0] e_hex;
      logic [1:0]  e_led;
      logic        e_pd;
   } vec_t;

   vec_t vecs [14];
   int   first_pd;
   logic [47:0] h012345;

   initial begin
`ifdef HEX_LZ_BLANK_EN
      h012345 = 48'hFFF9A4B09992;
`else
      h012345 = 48'hC0F9A4B09992;
`endif
      // rows are observed in the cycle before the edge that samples them
      vecs[0]  = '{1'b0, 24'h000000, 1'b0, 24'h0,      1'b0, 48'hFFFFFFFFFFFF, 2'b00, 1'b0};
      vecs[1]  = '{1'b1, 24'h012345, 1'b0, 24'h0,      1'b0, 48'hFFFFFFFFFFFF, 2'b00, 1'b0};
      vecs[2]  = '{1'b1, 24'h012345, 1'b0, 24'h0,      1'b0, h012345,          2'b01, 1'b0};
      vecs[3]  = '{1'b1, 24'h012345, 1'b0, 24'h0,      1'b0, h012345,          2'b01, 1'b0};
      vecs[4]  = '{1'b1, 24'hFFFFFF, 1'b0, 24'h0,      1'b0, h012345,          2'b01, 1'b0};
      vecs[5]  = '{1'b1, 24'hFFFFFF, 1'b0, 24'h0,      1'b0, h012345,          2'b01, 1'b1};
      vecs[6]  = '{1'b1, 24'hFFFFFF, 1'b0, 24'h0,      1'b0, {6{8'h8E}},       2'b01, 1'b0};
      vecs[7]  = '{1'b1, 24'hFFFFFF, 1'b0, 24'h0,      1'b1, {6{8'h8E}},       2'b01, 1'b0};
      vecs[8]  = '{1'b1, 24'hFFFFFF, 1'b0, 24'h0,      1'b1, {6{8'h8E}},       2'b01, 1'b0};
      vecs[9]  = '{1'b1, 24'hFFFFFF, 1'b0, 24'h0,      1'b0, {6{8'h8E}},       2'b01, 1'b0};
      vecs[10] = '{1'b1, 24'hFFFFFF, 1'b0, 24'h0,      1'b0, {6{8'h8E}},       2'b01, 1'b0};
      vecs[11] = '{1'b1, 24'hFFFFFF, 1'b0, 24'h0,      1'b0, {6{8'h8E}},       2'b01, 1'b1};
      vecs[12] = '{1'b0, 24'hFFFFFF, 1'b1, 24'h222222, 1'b0, {6{8'h8E}},       2'b01, 1'b0};
      vecs[13] = '{1'b0, 24'hFFFFFF, 1'b1, 24'h222222, 1'b0, {6{8'hA4}},       2'b10, 1'b0};

      reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0; hold = 1'b0;
      a_data = '0; b_data = '0;
      adv();
      adv();
      sample();
      chk("reset_hex", hex_all(), 48'hFFFFFFFFFFFF);
      chk("reset_ledr", 48'(ledr), 48'h0);
      chk("reset_page_done", 48'(page_done), 48'h0);
      adv();
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         sample();
         chk("idle_page_done", 48'(page_done), 48'h0);
         adv();
      end

      for (int i = 0; i < 14; i++) begin
         a_valid = vecs[i].a_v; a_data = vecs[i].a_d;
         b_valid = vecs[i].b_v; b_data = vecs[i].b_d;
         hold    = vecs[i].h;
         sample();
         chk($sformatf("vec%0d_hex", i), hex_all(), vecs[i].e_hex);
         chk($sformatf("vec%0d_ledr", i), 48'(ledr), 48'(vecs[i].e_led));
         chk($sformatf("vec%0d_page_done", i), 48'(page_done), 48'(vecs[i].e_pd));
         adv();
      end

      // reset mid-dwell in SHOW_B
      reset = 1'b1;
      tick();
      reset = 1'b0; b_valid = 1'b0;
      sample();
      chk("rst_mid_hex", hex_all(), 48'hFFFFFFFFFFFF);
      chk("rst_mid_ledr", 48'(ledr), 48'h0);
      chk("rst_mid_page_done", 48'(page_done), 48'h0);
      adv();

      // both valids together: A first, then alternate every DWELL cycles
      a_valid = 1'b1; b_valid = 1'b1; a_data = 24'h111111; b_data = 24'h222222;
      tick();
      for (int i = 0; i < 12; i++) begin
         sample();
         chk($sformatf("rr%0d_ledr", i), 48'(ledr), ((i / DWELL) % 2 == 0) ? 48'h1 : 48'h2);
         chk($sformatf("rr%0d_hex", i), hex_all(), ((i / DWELL) % 2 == 0) ? {6{8'hF9}} : {6{8'hA4}});
         chk($sformatf("rr%0d_page_done", i), 48'(page_done), 48'((i % DWELL) == DWELL - 1));
         adv();
      end
      a_valid = 1'b0; b_valid = 1'b0;
      tick();
      tick();

      // HOLD for 3 cycles delays the pulse by 3
      a_valid = 1'b1; a_data = 24'h123456; hold = 1'b1;
      tick();
      first_pd = -1;
      for (int i = 0; i < 20; i++) begin
         hold = (i < 3);
         sample();
         if (page_done) first_pd = i;
         adv();
         if (first_pd >= 0) break;
      end
      chk("hold_pd_cycle", 48'(first_pd), 48'(DWELL - 1 + 3));
      hold = 1'b1; a_valid = 1'b0; b_valid = 1'b1; b_data = 24'hABCDEF;
      sample();
      chk("abandon_page_done", 48'(page_done), 48'h0);
      adv();
      hold = 1'b0;
      sample();
      chk("abandon_ledr", 48'(ledr), 48'h2);
      chk("abandon_hex", hex_all(), 48'h88A186C683A1 ^ 48'h0 ^ {8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E} ^ 48'h88A186C683A1);
      adv();

      for (int i = 0; i < 500; i++) begin
         reset   = ($urandom_range(63) == 0);
         a_valid = ($urandom_range(4) != 0);
         b_valid = ($urandom_range(3) != 0);
         hold    = ($urandom_range(3) == 0);
         a_data  = 24'($urandom);
         b_data  = ($urandom_range(3) == 0) ? 24'($urandom_range(255)) : 24'($urandom);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/hex_page_scheduler.md
# hex_page_scheduler

Time-shares the six 7-segment digits (HEX0..HEX5) and the status LEDs between two display clients, A and B. Each client presents a 24-bit page of six hex nibbles. The scheduler shows each valid client's page for a fixed dwell period in round-robin order and blanks the display when no client is valid. It sits between the per-function datapaths and the board display pins, replacing direct per-switch digit assignment.

## Interface
- DWELL, default 50_000_000: cycles each page is shown; legal range 2..2^26; counter width $clog2(DWELL)
- CLOCK_50  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- A_VALID  in  1  client A requests display
- A_DATA  in  24  client A page; nibble k drives HEXk
- B_VALID  in  1  client B requests display
- B_DATA  in  24  client B page; nibble k drives HEXk
- HOLD  in  1  freezes the dwell counter while high
- HEX0..HEX5  out  8 each  active-low segments; bit7 = DP (always 1), bits6:0 = g..a
- LEDR  out  2  one-hot owner: [0] = A shown, [1] = B shown, 00 = idle
- PAGE_DONE  out  1  one-cycle pulse when a dwell period completes

## Operation
- States: IDLE, SHOW_A, SHOW_B. Registers: state, dwell counter `cnt`, 24-bit page register `page`.
- IDLE: A_VALID -> SHOW_A; else B_VALID -> SHOW_B; else stay. A has priority only from IDLE.
- On every entry into SHOW_x, including a restart of the same state: `page` <= x_DATA and `cnt` <= 0.
- In SHOW_x with own valid high: `cnt` increments each cycle unless HOLD is high.
- Expiry when `cnt` == DWELL-1 and HOLD is low:
  - PAGE_DONE = 1.
  - Next state is the other client if its valid is high.
  - Otherwise restart the same state if own valid is high (page reloaded).
  - Otherwise IDLE.
- Own valid low in SHOW_x at any cycle, HOLD or not: the next state is the other client if its valid is high, else IDLE. PAGE_DONE stays 0 (abandon).
- Abandon takes precedence over expiry when both occur in the same cycle.
- HEX digits are decoded combinationally from `page` nibbles: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E (hex).
- In IDLE, all HEX outputs = FF (blank).
- LEDR is decoded from state. PAGE_DONE is combinational from state, `cnt`, HOLD and own valid, and is high for exactly one cycle per completed dwell.
- Client data changes during a dwell are ignored until the next load.

## Timing
- Reset values: state IDLE, `cnt` 0, `page` 0, HEX0..HEX5 FF, LEDR 00, PAGE_DONE 0.
- Reset asserted mid-dwell returns to IDLE at the next edge, with no PAGE_DONE pulse.
- Latency: x_VALID sampled high in IDLE at edge n -> state, `page`, HEX and LEDR updated after edge n (1 cycle).
- Dwell with HOLD low: entry at edge n, PAGE_DONE high in cycle n+DWELL-1, new page shown after edge n+DWELL.
- Each cycle HOLD is high extends the dwell by one cycle. HOLD in IDLE has no effect.
- Both valids rising together in IDLE -> A first; B follows after A's dwell.
- Counter never wraps. It only restarts on state entry.

## Configuration
- HEX_LZ_BLANK_EN defined: leading-zero blanking.
  - Scanning from HEX5 down to HEX1, each digit whose nibble is 0 and has only zero nibbles above it outputs FF.
  - HEX0 is always shown, so a page of 000000 shows only "0" on HEX0.
- HEX_LZ_BLANK_EN undefined: all six digits always show their decoded nibble.

## Test plan
- Reset, then reset low with both valids low for 10 cycles -> HEX* = FF, LEDR = 00, PAGE_DONE never high.
- DWELL=4; A_VALID=1 with A_DATA=24'h012345, B_VALID=0 -> 1 cycle later HEX5..HEX0 = C0,F9,A4,B0,99,92 (macro off), LEDR = 01. PAGE_DONE pulses every 4 cycles and the page reloads (change A_DATA to 24'hFFFFFF mid-dwell -> shows 8E on all digits only after the next pulse).
- DWELL=4; both valids raised on the same cycle, A_DATA=24'h111111, B_DATA=24'h222222 -> LEDR sequence 01 for 4 cycles, 10 for 4 cycles, 01, ...; HEX alternates F9/A4.
- DWELL=4; in SHOW_A, HOLD high for 3 cycles -> PAGE_DONE delayed by exactly 3 cycles. Dropping A_VALID during HOLD with B valid -> switches to B next cycle, no pulse.
- Assert reset mid-dwell in SHOW_B -> next cycle IDLE: HEX all FF, LEDR 00, no PAGE_DONE.
- With HEX_LZ_BLANK_EN, A_DATA=24'h000A05 -> HEX5..HEX3 = FF, HEX2 = 88, HEX1 = C0, HEX0 = 92. A_DATA=0 -> HEX5..HEX1 FF, HEX0 C0.
